// File: rtl/afifo_rd_drain_if.sv
// Read-side bundle for the async FIFO drain: FIFO read port plus the framed
// valid/ready output stream. The drain side uses the master modport.
interface afifo_rd_drain_if #(
    parameter int DATA_W   = 8,
    parameter int PKTCNT_W = 16
);
    logic                empty;
    logic [DATA_W-1:0]   r_data;
    logic                read_en;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [PKTCNT_W-1:0] pkt_count;

    modport master (
        input  empty,
        input  r_data,
        input  out_ready,
        output read_en,
        output out_data,
        output out_valid,
        output out_last,
        output pkt_count
    );

    modport slave (
        output empty,
        output r_data,
        output out_ready,
        input  read_en,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  pkt_count
    );
endinterface

// File: rtl/afifo_rd_drain.sv
// Read-domain consumer of the async FIFO: hides the FIFO's one-cycle read
// latency behind a 2-entry skid buffer and frames bytes into fixed packets.
module afifo_rd_drain #(
    parameter int DATA_W   = 8,
    parameter int PKT_LEN  = 8,
    parameter int PKTCNT_W = 16
) (
    input  logic             i_r_clk,
    input  logic             i_clr,
    afifo_rd_drain_if.master io_bus
);
    localparam int IDX_W = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    function automatic logic [IDX_W-1:0] f_idx_adv(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    logic [1:0]          r_occ;
    logic                r_pend;
    logic                r_wptr;
    logic                r_rptr;
    logic [DATA_W-1:0]   r_buf [2];
    logic [IDX_W-1:0]    r_byte_idx;
    logic [PKTCNT_W-1:0] r_pkt_count;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;

    logic                w_pop;
    logic [2:0]          w_fill;
    logic                w_read_en;
    logic [DATA_W-1:0]   w_buf_nxt [2];
    logic                w_wptr_nxt;
    logic                w_rptr_nxt;
    logic [1:0]          w_occ_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [PKTCNT_W-1:0] w_pkt_nxt;
    logic                w_valid_nxt;
    logic                w_last_nxt;
    logic [DATA_W-1:0]   w_head_nxt;

    // Next-state of the skid buffer, framing counters and the read strobe.
    // Outputs are registered from next-state so they equal the spec view of
    // buf[rptr] / occ!=0 / byte_idx while staying flop-driven.
    always_comb begin
        w_pop       = r_out_valid & io_bus.out_ready;
        // Occupancy after this edge, counting the byte already in flight.
        w_fill      = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
        w_read_en   = ~i_clr & ~io_bus.empty & (w_fill < 3'd2);

        w_buf_nxt[0] = r_buf[0];
        w_buf_nxt[1] = r_buf[1];
        if (r_pend) begin
            if (r_wptr) begin
                w_buf_nxt[1] = io_bus.r_data;
            end else begin
                w_buf_nxt[0] = io_bus.r_data;
            end
        end else begin
            w_buf_nxt[0] = r_buf[0];
        end

        w_wptr_nxt = r_wptr ^ r_pend;
        w_rptr_nxt = r_rptr ^ w_pop;
        w_occ_nxt  = w_fill[1:0];

        if (w_pop) begin
            w_idx_nxt = f_idx_adv(r_byte_idx);
        end else begin
            w_idx_nxt = r_byte_idx;
        end

        if (w_pop && r_out_last) begin
            w_pkt_nxt = r_pkt_count + PKTCNT_W'(1);
        end else begin
            w_pkt_nxt = r_pkt_count;
        end

        w_valid_nxt = (w_occ_nxt != 2'd0);
        w_last_nxt  = w_valid_nxt & (w_idx_nxt == LAST_IDX);
        w_head_nxt  = w_rptr_nxt ? w_buf_nxt[1] : w_buf_nxt[0];
    end

    // State and registered outputs; clr also drops any read still in flight.
    always_ff @(posedge i_r_clk) begin
        if (i_clr) begin
            r_occ       <= 2'd0;
            r_pend      <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_buf[0]    <= {DATA_W{1'b0}};
            r_buf[1]    <= {DATA_W{1'b0}};
            r_byte_idx  <= {IDX_W{1'b0}};
            r_pkt_count <= {PKTCNT_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
        end else begin
            r_occ       <= w_occ_nxt;
            r_pend      <= w_read_en;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_buf[0]    <= w_buf_nxt[0];
            r_buf[1]    <= w_buf_nxt[1];
            r_byte_idx  <= w_idx_nxt;
            r_pkt_count <= w_pkt_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_out_data  <= w_head_nxt;
        end
    end

    assign io_bus.read_en   = w_read_en;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.pkt_count = r_pkt_count;
endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: queue-based FIFO source, queue model of the drain
// (buffered bytes, in-flight read, accepted-byte count) checked every cycle.
module tb_afifo_rd_drain;
    localparam int DW = 8;
    localparam int PL = 8;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    afifo_rd_drain_if #(.DATA_W(DW), .PKTCNT_W(PW)) bus ();

    afifo_rd_drain #(.DATA_W(DW), .PKT_LEN(PL), .PKTCNT_W(PW)) dut (
        .i_r_clk (clk),
        .i_clr   (clr),
        .io_bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    byte unsigned fifo_q[$];
    byte unsigned m_buf[$];
    byte unsigned m_fly[$];
    int           m_acc;
    bit           gap;
    bit           chk_en;

    byte unsigned got_d[$];
    bit           got_l[$];
    byte unsigned exp_q[$];
    int           re_cnt, cyc, first_re, first_val;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic clear_log();
        got_d.delete(); got_l.delete(); exp_q.delete();
        re_cnt = 0; cyc = 0; first_re = -1; first_val = -1;
    endtask

    task automatic load(input int n, input int base, input bit rnd);
        byte unsigned b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? byte'($urandom_range(0, 255)) : byte'(base + i);
            fifo_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // One clock: model-vs-DUT compare at negedge, then model/FIFO advance.
    task automatic step();
        bit exp_pop, exp_re, exp_valid, dut_re;
        int depth;
        byte unsigned b;
        bus.empty = gap || (fifo_q.size() == 0);
        @(negedge clk);
        exp_valid = (m_buf.size() != 0);
        exp_pop   = exp_valid && bus.out_ready;
        depth     = m_buf.size() + m_fly.size() - (exp_pop ? 1 : 0);
        exp_re    = !clr && !bus.empty && (depth < 2);
        if (chk_en) begin
            chk("read_en", bus.read_en, exp_re);
            chk("out_valid", bus.out_valid, exp_valid);
            chk("out_last", bus.out_last, exp_valid && ((m_acc % PL) == PL - 1));
            if (exp_valid) chk("out_data", bus.out_data, m_buf[0]);
            chk("pkt_count", bus.pkt_count, (m_acc / PL) % (1 << PW));
            chk("occ_pend_le2", (int'(dut.r_occ) + int'(dut.r_pend)) <= 2, 1);
        end
        if (bus.read_en) begin
            re_cnt++;
            if (first_re < 0) first_re = cyc;
        end
        if (bus.out_valid && first_val < 0) first_val = cyc;
        if (bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
        end
        dut_re = bus.read_en;
        @(posedge clk);
        #1;
        if (clr) begin
            m_buf.delete(); m_fly.delete(); m_acc = 0;
        end else begin
            if (exp_pop) begin
                void'(m_buf.pop_front());
                m_acc++;
            end
            if (m_fly.size() != 0) m_buf.push_back(m_fly.pop_front());
        end
        if (dut_re) begin
            chk("fifo_nonempty_on_read", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) begin
                b = fifo_q.pop_front();
                bus.r_data = b;
                if (exp_re) m_fly.push_back(b);
            end
        end else begin
            bus.r_data = byte'($urandom_range(0, 255));
        end
        cyc++;
    endtask

    task automatic check_seq(input string nm);
        chk({nm, "_count"}, got_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({nm, "_data"}, (i < got_d.size()) ? int'(got_d[i]) : -1, exp_q[i]);
            chk({nm, "_last"}, (i < got_l.size()) ? int'(got_l[i]) : -1, ((i + 1) % PL) == 0);
        end
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int g = 0;
        while (got_d.size() < n && g < budget) begin
            step();
            g++;
        end
        chk({nm, "_done_in_budget"}, got_d.size() >= n, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d expected finish", $time);
        $fatal(1);
    end

    initial begin
        chk_en = 1'b0; gap = 1'b0; clr = 1'b1;
        bus.out_ready = 1'b1; bus.r_data = '0; bus.empty = 1'b1;
        m_acc = 0;
        clear_log();
        load(8, 8'h00, 1'b0);
        bus.empty = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Reset with data available, then plain streaming of one packet.
        repeat (2) step();
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_read_cnt", re_cnt, 0);
        clr = 1'b0;
        re_cnt = 0; cyc = 0; first_re = -1; first_val = -1;
        repeat (14) step();
        chk("A_first_read_cycle", first_re, 0);
        chk("A_read_to_valid", first_val - first_re, 2);
        chk("A_read_pulses", re_cnt, 8);
        chk("A_pkt_count", bus.pkt_count, 1);
        check_seq("A");

        // Backpressure: only two reads while the sink stalls.
        clr = 1'b1; step(); clr = 1'b0;
        clear_log();
        load(8, 8'h00, 1'b0);
        bus.out_ready = 1'b0;
        repeat (10) step();
        chk("B_read_pulses", re_cnt, 2);
        chk("B_occ", dut.r_occ, 2);
        chk("B_hold_valid", bus.out_valid, 1);
        chk("B_hold_data", bus.out_data, 8'h00);
        bus.out_ready = 1'b1;
        repeat (14) step();
        check_seq("B");

        // Empty gaps every 3 cycles.
        clr = 1'b1; step(); clr = 1'b0;
        clear_log();
        load(16, 8'h10, 1'b0);
        for (int k = 0; k < 60; k++) begin
            gap = ((k / 3) % 2) == 0;
            step();
        end
        gap = 1'b0;
        check_seq("C");

        // Framing wrap with random backpressure and random data.
        clr = 1'b1; step(); clr = 1'b0;
        clear_log();
        load(24, 0, 1'b1);
        while (got_d.size() < 24 && cyc < 300) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("D_got24", got_d.size(), 24);
        chk("D_pkt_count3", bus.pkt_count, 3);
        load(16, 0, 1'b1);
        while (got_d.size() < 40 && cyc < 600) begin
            bus.out_ready = ($urandom_range(0, 1) != 0);
            gap = ($urandom_range(0, 4) == 0);
            step();
        end
        gap = 1'b0; bus.out_ready = 1'b1;
        chk("D_got40", got_d.size(), 40);
        chk("D_pkt_count_wrap", bus.pkt_count, 1);
        check_seq("D");

        // Reset mid-packet with a read in flight.
        clr = 1'b1; step(); clr = 1'b0;
        clear_log();
        load(16, 8'h40, 1'b0);
        run_until(5, 50, "E_pre");
        chk("E_inflight", dut.r_pend, 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("E_pkt_after_clr", bus.pkt_count, 0);
        chk("E_valid_after_clr", bus.out_valid, 0);
        chk("E_idx_after_clr", dut.r_byte_idx, 0);
        fifo_q.delete();
        clear_log();
        load(8, 8'h80, 1'b0);
        run_until(8, 40, "E_post");
        chk("E_pkt_count", bus.pkt_count, 1);
        check_seq("E");
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
